// File: rtl/adc_pack_pkg.sv
// Shared types and helpers for the ADC sample-pair frame packer.
package adc_pack_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR0,
    HDR1,
    HDR2,
    WAIT_A,
    WAIT_B,
    P0,
    P1,
    P2
  } state_e;

  typedef enum logic [1:0] {
    SEL_P0,
    SEL_P1,
    SEL_P2
  } pack_sel_e;

  localparam logic [7:0] HDR_B0_DEF = 8'hA5;
  localparam logic [7:0] HDR_B1_DEF = 8'h5A;

  // Two 12-bit samples occupy three bytes: A low, {B low nibble, A high nibble}, B high.
  function automatic logic [7:0] pack_byte(input pack_sel_e sel,
                                           input logic [11:0] a,
                                           input logic [11:0] b);
    logic [7:0] r;
    case (sel)
      SEL_P0:  r = a[7:0];
      SEL_P1:  r = {b[3:0], a[11:8]};
      default: r = b[11:4];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_out_reg.sv
// One-deep valid/ready output register; accepts a new word while the held one drains.
module byte_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_valid_i,
  input  logic [W-1:0] load_data_i,
  output logic         load_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign load_ready_o = !valid_q || out_ready_i;
  assign out_valid_o  = valid_q;
  assign out_data_o   = data_q;

  // Load when empty or draining this cycle, otherwise clear valid once consumed.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_valid_i && load_ready_o) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs 12-bit ADC sample pairs into 3 bytes and frames every FRAME_PAIRS pairs
// behind a 3-byte header {HDR_B0, HDR_B1, frame index}.
module adc_frame_packer
  import adc_pack_pkg::*;
#(
  parameter int unsigned FRAME_PAIRS = 256,
  parameter logic [7:0]  HDR_B0      = HDR_B0_DEF,
  parameter logic [7:0]  HDR_B1      = HDR_B1_DEF,
  parameter int unsigned DROP_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [11:0]       sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic [7:0]        frame_cnt_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              overflow_o
);

  localparam logic [15:0] LAST_PAIR = 16'(FRAME_PAIRS - 1);

  state_e            state_q, state_d;
  logic [15:0]       pair_q, pair_d;
  logic [7:0]        frame_q, frame_d;
  logic [11:0]       a_q, a_d;
  logic [11:0]       b_q, b_d;
  logic              ready_q, ready_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;

  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic              in_xfer;

  assign in_xfer        = sample_valid_i && ready_q;
  assign sample_ready_o = ready_q;
  assign frame_cnt_o    = frame_q;
  assign drop_cnt_o     = drop_q;
  assign overflow_o     = ovf_q;

  byte_out_reg #(
    .W(8)
  ) u_out (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_valid_i (ld_valid),
    .load_data_i  (ld_data),
    .load_ready_o (ld_ready),
    .out_valid_o  (byte_valid_o),
    .out_data_o   (byte_o),
    .out_ready_i  (byte_ready_i)
  );

  // State register plus frame datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pair_q  <= '0;
      frame_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ready_q <= 1'b0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      frame_q <= frame_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: byte-emitting states advance only once their byte is loaded.
  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    frame_d = frame_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE:   if (enable_i) state_d = HDR0;
      HDR0:   if (ld_ready) state_d = HDR1;
      HDR1:   if (ld_ready) state_d = HDR2;
      HDR2:   if (ld_ready) state_d = WAIT_A;
      WAIT_A: begin
        if (in_xfer) begin
          a_d     = sample_i;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (in_xfer) begin
          b_d     = sample_i;
          state_d = P0;
        end
      end
      P0:     if (ld_ready) state_d = P1;
      P1:     if (ld_ready) state_d = P2;
      P2: begin
        if (ld_ready) begin
          if (pair_q == LAST_PAIR) begin
            pair_d  = '0;
            frame_d = frame_q + 8'd1;
            state_d = IDLE;
          end else begin
            pair_d  = pair_q + 16'd1;
            state_d = WAIT_A;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: byte offered to the output register, and registered sample_ready
  // computed from the next state so it is high exactly in WAIT_A/WAIT_B.
  always_comb begin
    ld_valid = 1'b0;
    ld_data  = '0;
    case (state_q)
      HDR0: begin ld_valid = 1'b1; ld_data = HDR_B0;                      end
      HDR1: begin ld_valid = 1'b1; ld_data = HDR_B1;                      end
      HDR2: begin ld_valid = 1'b1; ld_data = frame_q;                     end
      P0:   begin ld_valid = 1'b1; ld_data = pack_byte(SEL_P0, a_q, b_q); end
      P1:   begin ld_valid = 1'b1; ld_data = pack_byte(SEL_P1, a_q, b_q); end
      P2:   begin ld_valid = 1'b1; ld_data = pack_byte(SEL_P2, a_q, b_q); end
      default: ;
    endcase
    ready_d = (state_d == WAIT_A) || (state_d == WAIT_B);
  end

  // Drop accounting: samples offered outside IDLE while not ready.
  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if ((state_q != IDLE) && sample_valid_i && !ready_q) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
module tb_adc_frame_packer;

  localparam int unsigned TB_PAIRS  = 2;
  localparam int unsigned TB_DROP_W = 4;
  localparam int          DROP_MAX  = 15;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 enable_i;
  logic [11:0]          sample_i;
  logic                 sample_valid_i;
  logic                 sample_ready_o;
  logic [7:0]           byte_o;
  logic                 byte_valid_o;
  logic                 byte_ready_i;
  logic [7:0]           frame_cnt_o;
  logic [TB_DROP_W-1:0] drop_cnt_o;
  logic                 overflow_o;

  always #5 clk = ~clk;

  adc_frame_packer #(
    .FRAME_PAIRS(TB_PAIRS),
    .DROP_W     (TB_DROP_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .byte_o         (byte_o),
    .byte_valid_o   (byte_valid_o),
    .byte_ready_i   (byte_ready_i),
    .frame_cnt_o    (frame_cnt_o),
    .drop_cnt_o     (drop_cnt_o),
    .overflow_o     (overflow_o)
  );

  int         n_checks   = 0;
  int         n_pass     = 0;
  logic [7:0] exp_q[$];
  int         frame_idx  = 0;
  int         drop_model = 0;
  int         rmode      = 0;   // 0 always, 1 one-of-3, 2 random 70%, 3 stalled
  int         rdy_cyc    = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_byte  = '0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream consumer pattern.
  initial begin
    byte_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rdy_cyc++;
      case (rmode)
        0:       byte_ready_i = 1'b1;
        1:       byte_ready_i = (rdy_cyc % 3 == 0);
        2:       byte_ready_i = ($urandom_range(0, 99) < 70);
        default: byte_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops on every output transfer, plus hold-stability while stalled.
  always @(negedge clk) begin
    if (rst_i) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) check_eq("hold_stable", {23'd0, byte_valid_o, byte_o}, {23'd0, 1'b1, prev_byte});
      if (byte_valid_o && byte_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", byte_o, $time);
        end else begin
          check_eq("byte", {24'd0, byte_o}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall = byte_valid_o && !byte_ready_i;
      prev_byte  = byte_o;
    end
  end

  // Offer one sample until accepted; hold=1 keeps valid high regardless of ready.
  task automatic send(input int s, input bit hold);
    int budget = 0;
    bit done   = 0;
    sample_i = 12'(s);
    while (!done) begin
      sample_valid_i = hold || (sample_ready_o && ($urandom_range(0, 9) > 1));
      if (sample_valid_i && !sample_ready_o && drop_model < DROP_MAX) drop_model++;
      done = sample_valid_i && sample_ready_o;
      tick();
      budget++;
      if (!done && budget > 2000) begin
        n_checks++;
        $display("FAIL send_timeout: got no accept expected accept within 2000 cycles");
        done = 1;
      end
    end
    if (!hold) sample_valid_i = 1'b0;
  endtask

  // Reference frame: header then 3 bytes per pair from plain arithmetic on the samples.
  task automatic run_frame(input bit fixed, input bit hold, input bit last);
    int smp[2*TB_PAIRS];
    int a, b;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(frame_idx % 256));
    frame_idx++;
    for (int p = 0; p < int'(TB_PAIRS); p++) begin
      a = (fixed && p == 0) ? 'hABC : $urandom_range(0, 4095);
      b = (fixed && p == 0) ? 'h123 : $urandom_range(0, 4095);
      smp[2*p]   = a;
      smp[2*p+1] = b;
      exp_q.push_back(8'(a % 256));
      exp_q.push_back(8'((b % 16) * 16 + a / 256));
      exp_q.push_back(8'(b / 16));
    end
    for (int i = 0; i < 2*int'(TB_PAIRS); i++) send(smp[i], hold && i != 0);
    sample_valid_i = 1'b0;
    if (last) begin
      tick();
      enable_i = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      tick();
      budget++;
    end
    check_eq({name, "_drain_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; sample_valid_i = 1'b0; sample_i = '0; rmode = 0;
    repeat (3) tick();
    check_eq("rst_byte_valid",   byte_valid_o,   0);
    check_eq("rst_byte",         byte_o,         0);
    check_eq("rst_sample_ready", sample_ready_o, 0);
    check_eq("rst_frame_cnt",    frame_cnt_o,    0);
    check_eq("rst_drop_cnt",     drop_cnt_o,     0);
    check_eq("rst_overflow",     overflow_o,     0);
    rst_i = 1'b0;

    // Free-flowing output, then 1-of-3 consumer.
    enable_i = 1'b1;
    rmode    = 0;
    run_frame(1, 0, 0);
    run_frame(0, 0, 0);
    rmode = 1;
    run_frame(1, 0, 0);
    run_frame(0, 0, 0);
    wait_drain("one_of_3");
    check_eq("frame_cnt_after4", frame_cnt_o, 32'(frame_idx % 256));
    check_eq("no_drops_yet",     drop_cnt_o,  0);

    // Samples offered every cycle while the consumer stalls for 20 cycles.
    rmode = 0;
    fork
      run_frame(0, 1, 0);
      begin
        repeat (6) tick();
        rmode = 3;
        repeat (20) tick();
        check_eq("ready_low_in_stall", sample_ready_o, 0);
        rmode = 0;
      end
    join
    check_eq("drop_cnt_stall", drop_cnt_o, 32'(drop_model));
    check_eq("overflow_stall", overflow_o, 32'(drop_model != 0));

    // Long run so the header index wraps FF -> 00; last frame drops enable mid-pair.
    rmode = 2;
    while (frame_idx < 258) run_frame(0, 0, frame_idx == 257);
    wait_drain("long_run");
    rmode = 0;
    repeat (20) begin
      sample_valid_i = 1'b1;
      sample_i       = 12'($urandom_range(0, 4095));
      tick();
    end
    sample_valid_i = 1'b0;
    check_eq("idle_drop_unchanged", drop_cnt_o,     32'(drop_model));
    check_eq("idle_ready_low",      sample_ready_o, 0);
    check_eq("idle_no_bytes",       byte_valid_o,   0);
    check_eq("idle_frame_cnt",      frame_cnt_o,    32'(frame_idx % 256));
    check_eq("overflow_sticky",     overflow_o,     32'(drop_model != 0));

    // Reset while a payload byte is held in the output register.
    enable_i = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(frame_idx % 256));
    send($urandom_range(0, 4095), 0);
    rmode = 3;
    send($urandom_range(0, 4095), 0);
    tick();
    check_eq("pre_reset_valid", byte_valid_o, 1);
    rst_i = 1'b1;
    tick();
    check_eq("mid_rst_byte_valid",   byte_valid_o,   0);
    check_eq("mid_rst_sample_ready", sample_ready_o, 0);
    check_eq("mid_rst_frame_cnt",    frame_cnt_o,    0);
    check_eq("mid_rst_drop_cnt",     drop_cnt_o,     0);
    check_eq("mid_rst_overflow",     overflow_o,     0);
    rst_i = 1'b0;
    exp_q.delete();
    drop_model = 0;
    frame_idx  = 0;
    rmode      = 0;

    run_frame(1, 0, 1);
    wait_drain("post_reset");
    repeat (5) tick();
    check_eq("post_reset_frame_cnt", frame_cnt_o,  1);
    check_eq("post_reset_idle",      byte_valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
